// File: rtl/rv32i_types_pkg.sv
// Shared types for the RV32I memory-side blocks: RAM port widths, arbiter states
// and requester identifiers.
package rv32i_types_pkg;

    localparam int unsigned RAM_AW   = 32;
    localparam int unsigned RAM_DW   = 32;
    localparam int unsigned RAM_BEW  = 4;
    localparam int unsigned CONSEC_W = 4;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
    typedef enum logic {SIDE_I, SIDE_D} arb_side_t;

endpackage

// File: rtl/ram_if.sv
// Simple RAM port: a cpu-side master issues addr/ren/wen/wdata/byte_en and
// waits while busy is high; rdata is valid in the cycle busy drops.
interface ram_if;

    logic [rv32i_types_pkg::RAM_AW-1:0]  addr;
    logic                                ren;
    logic                                wen;
    logic [rv32i_types_pkg::RAM_DW-1:0]  wdata;
    logic [rv32i_types_pkg::RAM_BEW-1:0] byte_en;
    logic [rv32i_types_pkg::RAM_DW-1:0]  rdata;
    logic                                busy;

    modport cpu (output addr, ren, wen, wdata, byte_en, input rdata, busy);
    modport ram (input addr, ren, wen, wdata, byte_en, output rdata, busy);

endinterface

// File: rtl/ram_arb_picker.sv
// Combinational winner select between the instruction and data requesters.
// When both request: data side if prioritised and the cap is not hit, else the side not granted last.
module ram_arb_picker
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic      req_i,
    input  logic      req_d,
    input  arb_side_t last_grant,
    input  logic      cap_hit,
    output arb_side_t winner
);

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        winner = SIDE_D;
        if (req_i && !req_d) begin
            winner = SIDE_I;
        end else if (req_i && req_d) begin
            if ((DATA_PRIORITY != 0) && !cap_hit) begin
                winner = SIDE_D;
            end else begin
                winner = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction fetch and data memory: registered grant FSM,
// round-robin with optional data priority, and a cap on back-to-back grants to one side.
module ram_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 1,
    parameter int unsigned MAX_CONSEC    = 4
) (
    input logic CLK,
    input logic RST,
    ram_if.ram  imem,
    ram_if.ram  dmem,
    ram_if.cpu  mem
);

    localparam logic [CONSEC_W-1:0] CAP        = CONSEC_W'(MAX_CONSEC - 1);
    localparam logic [CONSEC_W-1:0] CONSEC_SAT = '1;

    arb_state_t          state_q, state_d;
    arb_side_t           last_grant_q, last_grant_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;

    logic      req_i, req_d, req_own, req_other, cap_hit;
    arb_side_t own_side, pick_last, winner;

    assign req_i = imem.ren | imem.wen;
    assign req_d = dmem.ren | dmem.wen;

    always_comb begin
        own_side  = (state_q == GNT_I) ? SIDE_I : SIDE_D;
        req_own   = (state_q == GNT_I) ? req_i : req_d;
        req_other = (state_q == GNT_I) ? req_d : req_i;
        pick_last = (state_q == IDLE) ? last_grant_q : own_side;
        cap_hit   = (state_q != IDLE) && (consec_q == CAP);
    end

    ram_arb_picker #(
        .DATA_PRIORITY(DATA_PRIORITY)
    ) u_picker (
        .req_i     (req_i),
        .req_d     (req_d),
        .last_grant(pick_last),
        .cap_hit   (cap_hit),
        .winner    (winner)
    );

    // mem.busy only steers state_d; the picker never sees it.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        consec_d     = consec_q;
        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    state_d = (winner == SIDE_I) ? GNT_I : GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (!req_own) begin
                    state_d = IDLE;
                end else if (!mem.busy) begin
                    last_grant_d = own_side;
                    if (winner != own_side) begin
                        state_d  = (winner == SIDE_I) ? GNT_I : GNT_D;
                        consec_d = '0;
                    end else if (!req_other) begin
                        consec_d = '0;
                    end else if (consec_q != CONSEC_SAT) begin
                        consec_d = consec_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every flop updates from values sampled before the edge.
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= SIDE_D;
            consec_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            consec_q     <= consec_d;
        end
    end

    // A write wins over a simultaneous read from the same requester.
    always_comb begin
        mem.addr    = '0;
        mem.wdata   = '0;
        mem.byte_en = '0;
        mem.ren     = 1'b0;
        mem.wen     = 1'b0;
        imem.busy   = 1'b1;
        imem.rdata  = '0;
        dmem.busy   = 1'b1;
        dmem.rdata  = '0;
        case (state_q)
            GNT_I: begin
                mem.addr    = imem.addr;
                mem.wdata   = imem.wdata;
                mem.byte_en = imem.byte_en;
                mem.wen     = imem.wen;
                mem.ren     = imem.ren & ~imem.wen;
                imem.busy   = mem.busy;
                imem.rdata  = mem.rdata;
            end
            GNT_D: begin
                mem.addr    = dmem.addr;
                mem.wdata   = dmem.wdata;
                mem.byte_en = dmem.byte_en;
                mem.wen     = dmem.wen;
                mem.ren     = dmem.ren & ~dmem.wen;
                dmem.busy   = mem.busy;
                dmem.rdata  = mem.rdata;
            end
            default: ;
        endcase
    end

endmodule
